// File: rtl/sensor_conditioner_pkg.sv
// Shared constants for the track-sensor conditioning stage.
package sensor_conditioner_pkg;

    localparam int unsigned N_SENSORS_DEF       = 6;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned CNT_W_DEF           = 5;

    // Sensor channel indices: S_Clean[SENS_n] feeds selector input Sn.
    typedef enum int unsigned {
        SENS_1 = 0,
        SENS_2 = 1,
        SENS_3 = 2,
        SENS_4 = 3,
        SENS_5 = 4,
        SENS_6 = 5
    } sensor_idx_e;

    // Width of a counter able to hold the values 0..max_val.
    function automatic int unsigned count_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sensor_debounce_channel.sv
// One sensor channel: 2-flop synchronizer, debounce counter, edge pulse registers.
module sensor_debounce_channel
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw line, accept a new level only after it has been stable long enough.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clean <= sync2;
                cnt   <= '0;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces all track-sensor lines and raises Enable once inputs have settled after reset.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned N_SENSORS       = N_SENSORS_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N_SENSORS-1:0] SensorRaw,
    output logic [N_SENSORS-1:0] S_Clean,
    output logic [N_SENSORS-1:0] RisePulse,
    output logic [N_SENSORS-1:0] FallPulse,
    output logic                 Enable
);

    localparam int unsigned SETTLE_W = count_width(DEBOUNCE_CYCLES + 2);
    // Enable is registered, so it is set on the edge where the count would reach DEBOUNCE_CYCLES+2.
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(DEBOUNCE_CYCLES + 1);

    logic [SETTLE_W-1:0] settle;

    genvar g;
    generate
        for (g = 0; g < N_SENSORS; g++) begin : g_chan
            sensor_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_chan (
                .Clk   (Clk),
                .Reset (Reset),
                .raw   (SensorRaw[g]),
                .clean (S_Clean[g]),
                .rise  (RisePulse[g]),
                .fall  (FallPulse[g])
            );
        end
    endgenerate

    // Count cycles since reset release; Enable latches high once the settle period has elapsed.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            settle <= '0;
            Enable <= 1'b0;
        end else if (!Enable) begin
            if (settle == SETTLE_LAST) begin
                Enable <= 1'b1;
            end else begin
                settle <= settle + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed self-checking bench for sensor_conditioner (DEBOUNCE_CYCLES=4, CNT_W=3).
module tb_sensor_conditioner;

    localparam int unsigned N  = 6;
    localparam int unsigned DB = 4;

    logic         Clk;
    logic         Reset;
    logic [N-1:0] SensorRaw;
    logic [N-1:0] S_Clean;
    logic [N-1:0] RisePulse;
    logic [N-1:0] FallPulse;
    logic         Enable;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    sensor_conditioner #(
        .N_SENSORS       (N),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (3)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .SensorRaw (SensorRaw),
        .S_Clean   (S_Clean),
        .RisePulse (RisePulse),
        .FallPulse (FallPulse),
        .Enable    (Enable)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // 1: reset held with all sensors high
        Reset     = 1'b1;
        SensorRaw = 6'b111111;
        #2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_clean", 32'(S_Clean), 32'h0);
            check("rst_rise", 32'(RisePulse), 32'h0);
            check("rst_fall", 32'(FallPulse), 32'h0);
            check("rst_enable", 32'(Enable), 32'h0);
        end
        SensorRaw = '0;
        Reset     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("settle_enable_low", 32'(Enable), 32'h0);
        end
        step();
        check("settle_enable_high", 32'(Enable), 32'h1);

        // 2: channel 0 rises and is held; change lands after edge k+5
        SensorRaw[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ch0_wait_clean", 32'(S_Clean), 32'h0);
            check("ch0_wait_rise", 32'(RisePulse), 32'h0);
        end
        step();
        check("ch0_clean", 32'(S_Clean), 32'h01);
        check("ch0_rise", 32'(RisePulse), 32'h01);
        step();
        check("ch0_rise_end", 32'(RisePulse), 32'h0);
        check("ch0_clean_hold", 32'(S_Clean), 32'h01);

        // 3: channel 2 glitch of DB-1 cycles is rejected
        SensorRaw[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        SensorRaw[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("ch2_glitch_clean", 32'(S_Clean), 32'h01);
            check("ch2_glitch_rise", 32'(RisePulse), 32'h0);
            check("ch2_glitch_fall", 32'(FallPulse), 32'h0);
        end

        // 4: channel 4 bounces 1,0,1 then holds; count restarts after the bounce
        SensorRaw[4] = 1'b1;
        step();
        SensorRaw[4] = 1'b0;
        step();
        SensorRaw[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ch4_bounce_clean", 32'(S_Clean[4]), 32'h0);
            check("ch4_bounce_rise", 32'(RisePulse), 32'h0);
        end
        step();
        check("ch4_clean", 32'(S_Clean), 32'h11);
        check("ch4_rise", 32'(RisePulse), 32'h10);
        step();
        check("ch4_rise_end", 32'(RisePulse), 32'h0);

        // 5: channels 1 and 5 rise together, later fall together
        SensorRaw = SensorRaw | 6'b100010;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ch15_wait_rise", 32'(RisePulse), 32'h0);
        end
        step();
        check("ch15_rise", 32'(RisePulse), 32'h22);
        check("ch15_clean_hi", 32'(S_Clean), 32'h33);
        check("ch15_nofall", 32'(FallPulse), 32'h0);
        step();
        check("ch15_rise_end", 32'(RisePulse), 32'h0);
        SensorRaw = SensorRaw & ~6'b100010;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ch15_wait_fall", 32'(FallPulse), 32'h0);
        end
        step();
        check("ch15_fall", 32'(FallPulse), 32'h22);
        check("ch15_clean_lo", 32'(S_Clean), 32'h11);
        check("ch15_norise", 32'(RisePulse), 32'h0);
        step();
        check("ch15_fall_end", 32'(FallPulse), 32'h0);

        // 6: reset mid-debounce on channel 3 (cnt==2 after 4 edges)
        SensorRaw[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("ch3_pre_clean", 32'(S_Clean), 32'h11);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_clean", 32'(S_Clean), 32'h0);
        check("midrst_rise", 32'(RisePulse), 32'h0);
        check("midrst_fall", 32'(FallPulse), 32'h0);
        check("midrst_enable", 32'(Enable), 32'h0);
        step();
        step();
        SensorRaw = '0;
        Reset     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("resettle_enable_low", 32'(Enable), 32'h0);
            check("resettle_clean", 32'(S_Clean), 32'h0);
            check("resettle_rise", 32'(RisePulse), 32'h0);
        end
        step();
        check("resettle_enable_high", 32'(Enable), 32'h1);
        check("resettle_clean_final", 32'(S_Clean), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
